// File: rtl/rgb_frame_streamer_pkg.sv
// rgb_frame_streamer_pkg
// Shared definitions for the RGB frame streamer that follows the CFA interpolation stage:
// streamer FSM state encodings, framing-bit positions inside a skid FIFO entry, and the
// bit positions of the red/green/blue samples inside a packed pixel.
package rgb_frame_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FIN    = 2'd3
    } stream_state_t;

    // Framing bits sit in the low bits of a FIFO entry, packed pixel above them.
    localparam int FRM_EOF  = 0;
    localparam int FRM_EOL  = 1;
    localparam int FRM_SOF  = 2;
    localparam int FRM_BITS = 3;

    // Packed pixel is {red, green, blue} with red in the MSBs.
    function automatic int red_lsb(input int data_w);
        return 2 * data_w;
    endfunction

    function automatic int green_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int blue_lsb(input int data_w);
        return 0 * data_w;
    endfunction

endpackage

// File: rtl/rgb_skid_fifo.sv
// rgb_skid_fifo
// Two-entry FIFO that absorbs the one-cycle plane read latency so the output stream can
// run at one beat per cycle while honouring backpressure.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   push        write push_data this cycle
//   pop         consume the head entry this cycle
//   push_data   entry to write
//   count       number of valid entries (0..2)
//   head_data   oldest entry; stable until popped
module rgb_skid_fifo #(
    parameter int Width = 39
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] push_data,
    output logic [1:0]       count,
    output logic [Width-1:0] head_data
);

    logic [Width-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    // When full, a push is only ever paired with a pop, and both pointers then address
    // the slot being consumed, so the write replaces the entry leaving the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/rgb_frame_streamer.sv
// rgb_frame_streamer
// After the CFA stage pulses done, reads the green/red/blue planes in raster order and
// emits one packed {red, green, blue} pixel per beat with sof/eol/eof framing.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start                     begins a frame (ignored unless idle)
//   rowMax, colMax            frame height/width, sampled at start
//   readAddress, readEnable   shared plane read port; data returns one cycle later
//   greenRead/redRead/blueRead plane read data
//   pixelValid/pixelReady     output stream handshake
//   pixelData, sof, eol, eof  output beat and framing
//   busy, done                frame in progress / one-cycle completion pulse
//
// state  | meaning
// IDLE   | waiting for start
// STREAM | issuing plane reads, one per free FIFO slot
// DRAIN  | all reads issued; waiting for FIFO and read pipeline to empty
// FIN    | done pulse, then back to IDLE
module rgb_frame_streamer
    import rgb_frame_streamer_pkg::*;
#(
    parameter int addressBitWidth = 17,
    parameter int rowBitWidth     = 11,
    parameter int colBitWidth     = 11,
    parameter int dataBitWidth    = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [rowBitWidth-1:0]    rowMax,
    input  logic [colBitWidth-1:0]    colMax,
    output logic [addressBitWidth-1:0] readAddress,
    output logic                      readEnable,
    input  logic [dataBitWidth-1:0]   greenRead,
    input  logic [dataBitWidth-1:0]   redRead,
    input  logic [dataBitWidth-1:0]   blueRead,
    output logic                      pixelValid,
    input  logic                      pixelReady,
    output logic [3*dataBitWidth-1:0] pixelData,
    output logic                      sof,
    output logic                      eol,
    output logic                      eof,
    output logic                      busy,
    output logic                      done
);

    localparam int PIXEL_W = 3 * dataBitWidth;
    localparam int ENTRY_W = PIXEL_W + FRM_BITS;

    localparam logic [addressBitWidth-1:0] ADDR_ONE = {{(addressBitWidth-1){1'b0}}, 1'b1};
    localparam logic [rowBitWidth-1:0]     ROW_ONE  = {{(rowBitWidth-1){1'b0}}, 1'b1};
    localparam logic [colBitWidth-1:0]     COL_ONE  = {{(colBitWidth-1){1'b0}}, 1'b1};

    stream_state_t              state_q;
    stream_state_t              state_d;
    logic [rowBitWidth-1:0]     row_max_q;
    logic [rowBitWidth-1:0]     row_q;
    logic [colBitWidth-1:0]     col_max_q;
    logic [colBitWidth-1:0]     col_q;
    logic [addressBitWidth-1:0] addr_q;
    logic [addressBitWidth-1:0] last_addr_q;
    logic [addressBitWidth-1:0] total_pix;
    logic                       in_flight_q;
    logic [FRM_BITS-1:0]        frm_q;
    logic [FRM_BITS-1:0]        frm_issue;
    logic [1:0]                 fifo_count;
    logic [ENTRY_W-1:0]         push_entry;
    logic [ENTRY_W-1:0]         head_entry;
    logic [2:0]                 occupancy;
    logic [2:0]                 limit;
    logic                       pop;
    logic                       issue;
    logic                       frame_accept;
    logic                       frame_empty;
    logic                       col_last;
    logic                       row_last;

    // Product of operands truncated to the address width equals the full product
    // truncated, so the multiply can be done directly at address width.
    assign total_pix    = addressBitWidth'(rowMax) * addressBitWidth'(colMax);
    assign frame_empty  = (rowMax == '0) || (colMax == '0);
    assign frame_accept = (state_q == ST_IDLE) && start;

    assign pop = pixelValid && pixelReady;

    // Slots committed next cycle: stored entries plus the read in flight, minus this pop.
    assign occupancy = {1'b0, fifo_count} + {2'b00, in_flight_q};
    assign limit     = 3'd1 + {2'b00, pop};
    assign issue     = (state_q == ST_STREAM) && (occupancy <= limit);

    assign col_last = (col_q == col_max_q - COL_ONE);
    assign row_last = (row_q == row_max_q - ROW_ONE);

    always_comb begin
        frm_issue          = '0;
        frm_issue[FRM_SOF] = (row_q == '0) && (col_q == '0);
        frm_issue[FRM_EOL] = col_last;
        frm_issue[FRM_EOF] = col_last && row_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = frame_empty ? ST_FIN : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (issue && (addr_q == last_addr_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave as the last entry is accepted so done lands the very next cycle.
                if (!in_flight_q && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_max_q   <= '0;
            col_max_q   <= '0;
            last_addr_q <= '0;
            addr_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            in_flight_q <= 1'b0;
            frm_q       <= '0;
        end else begin
            in_flight_q <= issue;
            if (issue) begin
                frm_q <= frm_issue;
            end
            if (frame_accept) begin
                row_max_q   <= rowMax;
                col_max_q   <= colMax;
                last_addr_q <= total_pix - ADDR_ONE;
                addr_q      <= '0;
                row_q       <= '0;
                col_q       <= '0;
            end else if (issue) begin
                addr_q <= addr_q + ADDR_ONE;
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_q + ROW_ONE;
                end else begin
                    col_q <= col_q + COL_ONE;
                end
            end
        end
    end

    always_comb begin
        push_entry = '0;
        push_entry[FRM_BITS + red_lsb(dataBitWidth)   +: dataBitWidth] = redRead;
        push_entry[FRM_BITS + green_lsb(dataBitWidth) +: dataBitWidth] = greenRead;
        push_entry[FRM_BITS + blue_lsb(dataBitWidth)  +: dataBitWidth] = blueRead;
        push_entry[FRM_BITS-1:0] = frm_q;
    end

    rgb_skid_fifo #(
        .Width(ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (in_flight_q),
        .pop      (pop),
        .push_data(push_entry),
        .count    (fifo_count),
        .head_data(head_entry)
    );

    assign readAddress = addr_q;
    assign readEnable  = issue;
    assign pixelValid  = (fifo_count != 2'd0);
    assign pixelData   = head_entry[FRM_BITS +: PIXEL_W];
    assign sof         = pixelValid && head_entry[FRM_SOF];
    assign eol         = pixelValid && head_entry[FRM_EOL];
    assign eof         = pixelValid && head_entry[FRM_EOF];
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_FIN);

endmodule
